aes_round_key_store: RTL
========================

// Module: aes_round_key_store
// PURPOSE
// - Upstream of the decipher round engine: expands a 128/256-bit cipher key into all round keys.
// - Stores all round keys and serves round_key[round] to the round engine, which walks round from 14/10 down to 0.
// - Expansion runs once per key. It produces one 128-bit round key per cycle through a 32-bit forward S-box.
// - The S-box is shared with the cipher datapath, so this block sees it through sboxw/new_sboxw.
// PARAMETERS (localparams, not overridable)
// - AES128_ROUNDS  4'ha  last round index for 128-bit keys (11 keys: 0..10)
// - AES256_ROUNDS  4'he  last round index for 256-bit keys (15 keys: 0..14)
// PORTS
// - clk        in   1    clock, all flops rise-edge
// - reset      in   1    synchronous, active-high reset
// - init       in   1    start expansion pulse; sampled only in IDLE
// - keylen     in   1    0 = AES-128, 1 = AES-256; sampled with init
// - key        in   256  cipher key; AES-128 uses key[255:128]; sampled with init
// - round      in   4    round key index to read
// - round_key  out  128  store[round], combinational read
// - ready      out  1    1 = idle, key store valid/stable
// - sboxw      out  32   word to shared forward S-box (32'h0 when unused)
// - new_sboxw  in   32   SubWord(sboxw), combinational return
// BEHAVIOUR
// - Reset, one clock with reset=1:
//   - ready=1, state IDLE, all 15 store entries = 128'h0, rcon=8'h01, key counter=0.
//   - Reset overrides everything, including mid-expansion: the partial key set is discarded.
// - Words: a key is {w0,w1,w2,w3}, w0 = bits [127:96]. prev = last stored key, prev2 = key before it.
// - FSM IDLE:
//   - init=1 latches key and keylen, ready<=0, next state INIT.
//   - init=0: stay in IDLE.
// - FSM INIT (1 cycle):
//   - store[0] <= key[255:128].
//   - If AES-256, also store[1] <= key[127:0].
//   - rcon <= 8'h01; counter <= 1 (AES-128) or 2 (AES-256); next state GEN.
// - FSM GEN (1 key per cycle):
//   - Step value t:
//     - AES-128, and AES-256 with even counter: t = SubWord(RotWord(prev.w3)) ^ {rcon,24'h0}; rcon advances after use.
//     - AES-256 with odd counter: t = SubWord(prev.w3), no rotate, no rcon.
//   - RotWord(w) = {w[23:0], w[31:24]}.
//   - rcon advances by xtime: {r[6:0],1'b0} ^ (8'h1b & {8{r[7]}}).
//   - Base key b = prev (AES-128) or prev2 (AES-256).
//   - n0 = b.w0^t, n1 = b.w1^n0, n2 = b.w2^n1, n3 = b.w3^n2; store[counter] <= {n0,n1,n2,n3}.
//   - After writing the last index (10 or 14), next state DONE; otherwise counter+1.
// - FSM DONE (1 cycle): ready<=1, next state IDLE.
// - Latency: ready reads 1 on the 13th (AES-128) or 16th (AES-256) rising edge after the edge that sampled init.
// - init while ready=0 is ignored and does not restart expansion.
// - Read path:
//   - round_key is store[round] in every state.
//   - During expansion it may return stale or partial entries; the consumer waits for ready.
//   - round > last index for the latched keylen returns 128'h0.
// - A new init after DONE overwrites all entries. With AES-128, entries 11..14 are cleared to 0 in INIT.
// - keylen and key changes while busy have no effect; only the values latched at init are used.
// CONFIGURATION
// - Macro AES_ROUND_KEY_STORE_AES256_EN.
// - Defined: behaviour as above, 15-entry store.
// - Undefined:
//   - AES-128 only; keylen and key[127:0] are ignored.
//   - 11-entry store; round > 10 returns 0.
//   - The odd-step SubWord path and prev2 are not built; latency is always 13.
// TESTING
// - Reset mid-GEN (cycle 5 after init) -> next cycle ready=1, round_key=0 for all rounds, IDLE.
// - AES-128 key 2b7e151628aed2a6abf7158809cf4f3c:
//   - ready=1 at edge 13.
//   - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
//   - round 1 = a0fafe1788542cb123a339392a6c7605.
//   - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 11 = 0.
// - AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//   - ready=1 at edge 16.
//   - round 1 = 1f352c073b6108d72d9810a30914dff4.
//   - round 14 = fe4890d1e6188d0b046df344706c631e.
// - init re-pulsed every cycle during AES-256 expansion -> ready rises on edge 16 only, keys as in the AES-256 test.
// - AES-256 expansion, then AES-128 init -> rounds 0..10 as in the AES-128 test, rounds 11..14 = 0.
// - Build without the macro, keylen=1 with the AES-128 key -> identical results to the AES-128 test, ready at edge 13.

Source files
------------

// File: rtl/aes_round_key_store.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_key_store
// Brief    : Expands an AES cipher key into all round keys, one per cycle,
//            using the shared forward S-box, and serves store[round].
//            Macro AES_ROUND_KEY_STORE_AES256_EN adds AES-256 support.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_key_store (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         keylen,
    input  logic [255:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    localparam logic [3:0] AES128_ROUNDS = 4'ha;
    localparam logic [3:0] AES256_ROUNDS = 4'he;

`ifdef AES_ROUND_KEY_STORE_AES256_EN
    localparam int c_NUM_KEYS = 15;
    localparam int c_KEY_W    = 256;
`else
    localparam int c_NUM_KEYS = 11;
    localparam int c_KEY_W    = 128;
`endif

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_INIT = 2'd1;
    localparam logic [1:0] c_ST_GEN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [127:0]       r_store [c_NUM_KEYS];
    logic [7:0]         r_rcon;
    logic [3:0]         r_counter;
    logic [c_KEY_W-1:0] r_key;
    logic               r_ready;

    logic               w_aes256;
    logic               w_odd;
    logic [3:0]         w_last;
    logic [127:0]       w_prev;
    logic [127:0]       w_base;
    logic [31:0]        w_t;
    logic [31:0]        w_n0, w_n1, w_n2, w_n3;
    logic [31:0]        w_sboxw;

`ifdef AES_ROUND_KEY_STORE_AES256_EN
    logic               r_keylen;
    logic [127:0]       w_prev2;

    assign w_aes256 = r_keylen;
    assign w_odd    = r_keylen & r_counter[0];
    assign w_prev2  = r_store[r_counter - 4'd2];
    assign w_base   = r_keylen ? w_prev2 : w_prev;
`else
    logic               w_unused;

    assign w_unused = ^{keylen, key[127:0]};
    assign w_aes256 = 1'b0;
    assign w_odd    = 1'b0;
    assign w_base   = w_prev;
`endif

    assign w_last = w_aes256 ? AES256_ROUNDS : AES128_ROUNDS;
    assign w_prev = r_store[r_counter - 4'd1];

    // SubWord is bytewise, so rotating before the S-box equals SubWord(RotWord(w)).
    always_comb begin
        w_sboxw = 32'h0;
        if (r_state == c_ST_GEN) begin
            w_sboxw = w_odd ? w_prev[31:0] : {w_prev[23:0], w_prev[31:24]};
        end
    end

    assign w_t  = w_odd ? new_sboxw : (new_sboxw ^ {r_rcon, 24'h0});
    assign w_n0 = w_base[127:96] ^ w_t;
    assign w_n1 = w_base[95:64]  ^ w_n0;
    assign w_n2 = w_base[63:32]  ^ w_n1;
    assign w_n3 = w_base[31:0]   ^ w_n2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_ready   <= 1'b1;
            r_rcon    <= 8'h01;
            r_counter <= 4'd0;
            r_key     <= '0;
`ifdef AES_ROUND_KEY_STORE_AES256_EN
            r_keylen  <= 1'b0;
`endif
            for (int i = 0; i < c_NUM_KEYS; i++) begin
                r_store[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (init) begin
                        r_key   <= key[255 -: c_KEY_W];
`ifdef AES_ROUND_KEY_STORE_AES256_EN
                        r_keylen <= keylen;
`endif
                        r_ready <= 1'b0;
                        r_state <= c_ST_INIT;
                    end
                end
                c_ST_INIT: begin
                    r_store[0] <= r_key[c_KEY_W-1 -: 128];
                    // Clearing every later entry leaves no stale AES-256 keys behind an AES-128 set.
                    for (int i = 1; i < c_NUM_KEYS; i++) begin
                        r_store[i] <= '0;
                    end
`ifdef AES_ROUND_KEY_STORE_AES256_EN
                    if (r_keylen) begin
                        r_store[1] <= r_key[127:0];
                    end
`endif
                    r_rcon    <= 8'h01;
                    r_counter <= w_aes256 ? 4'd2 : 4'd1;
                    r_state   <= c_ST_GEN;
                end
                c_ST_GEN: begin
                    r_store[r_counter] <= {w_n0, w_n1, w_n2, w_n3};
                    if (!w_odd) begin
                        r_rcon <= {r_rcon[6:0], 1'b0} ^ (8'h1b & {8{r_rcon[7]}});
                    end
                    if (r_counter == w_last) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_counter <= r_counter + 4'd1;
                    end
                end
                c_ST_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign round_key = (round <= w_last) ? r_store[round] : 128'h0;
    assign ready     = r_ready;
    assign sboxw     = w_sboxw;

endmodule
`default_nettype wire
